// File: rtl/axi_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions used by the AXI4-Lite master and slave.
//   - Response codes carried on bresp / rresp.
//   - State encoding of the axi_lite_master transaction FSM.
// No ports (package).
// ----------------------------------------------------------------------------
package axi_lite_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// ----------------------------------------------------------------------------
// axi_lite_master
// AXI4-Lite initiator. Accepts single-beat commands on a valid/ready port,
// runs one AXI4-Lite write or read transaction at a time and presents the
// slave's response on a valid/ready response port.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb         command payload (write=1 / read=0)
//   rsp_valid/rsp_ready          response handshake
//   rsp_write, rsp_rdata,
//   rsp_resp, rsp_timeout        response payload
//   awaddr/awvalid/awready       AXI write address channel
//   wdata/wstrb/wvalid/wready    AXI write data channel
//   bresp/bvalid/bready          AXI write response channel
//   araddr/arvalid/arready       AXI read address channel
//   rdata/rresp/rvalid/rready    AXI read data channel
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width (32 only)
//   TIMEOUT  cycles allowed in any AXI wait state before aborting, 0 = never
// ----------------------------------------------------------------------------
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   // command port
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   // response port
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   // AXI write address
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   // AXI write data
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   // AXI write response
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   // AXI read address
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   // AXI read data
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready
);

   // Wait counter width; kept at one bit when the timeout is disabled so the
   // declaration stays legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   // Abort on the edge at which the counter would reach TIMEOUT, so a wait
   // state lasts exactly TIMEOUT cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   master_state_t       state_reg, state_next;

   logic                cmd_ready_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [DATA_W/8-1:0] wstrb_reg;
   logic                write_reg;
   logic                aw_done_reg;
   logic                w_done_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [1:0]          resp_reg;
   logic                timeout_reg;
   logic [CNT_W-1:0]    cnt_reg;

   logic                accept;
   logic                aw_fire;
   logic                w_fire;
   logic                timeout_hit;
   logic                abort;

   // ------------------------------------------------------------------
   // Outputs: registered or decoded from registered state only
   // ------------------------------------------------------------------
   assign cmd_ready   = cmd_ready_reg;
   assign awaddr      = addr_reg;
   assign araddr      = addr_reg;
   assign wdata       = wdata_reg;
   assign wstrb       = wstrb_reg;
   assign awvalid     = (state_reg == WR_REQ) && !aw_done_reg;
   assign wvalid      = (state_reg == WR_REQ) && !w_done_reg;
   assign bready      = (state_reg == WR_RESP);
   assign arvalid     = (state_reg == RD_REQ);
   assign rready      = (state_reg == RD_DATA);
   assign rsp_valid   = (state_reg == RSP);
   assign rsp_write   = write_reg;
   assign rsp_rdata   = rdata_reg;
   assign rsp_resp    = resp_reg;
   assign rsp_timeout = timeout_reg;

   assign accept      = cmd_valid && cmd_ready_reg;
   assign aw_fire     = awvalid && awready;
   assign w_fire      = wvalid && wready;
   assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      abort      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently, in any order.
            if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
               state_next = WR_RESP;
            end else if (timeout_hit) begin
               state_next = RSP;
               abort      = 1'b1;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               state_next = RSP;
            end else if (timeout_hit) begin
               state_next = RSP;
               abort      = 1'b1;
            end
         end
         RD_REQ: begin
            if (arready) begin
               state_next = RD_DATA;
            end else if (timeout_hit) begin
               state_next = RSP;
               abort      = 1'b1;
            end
         end
         RD_DATA: begin
            if (rvalid) begin
               state_next = RSP;
            end else if (timeout_hit) begin
               state_next = RSP;
               abort      = 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cmd_ready_reg <= 1'b0;
         cnt_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         // Registered so that cmd_ready stays low while rst is high and
         // rises one cycle after the response handshake.
         cmd_ready_reg <= (state_next == IDLE);
         if (state_next != state_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Command capture, channel bookkeeping and response capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         write_reg   <= 1'b0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         rdata_reg   <= '0;
         resp_reg    <= OKAY;
         timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  addr_reg    <= cmd_addr;
                  wdata_reg   <= cmd_wdata;
                  wstrb_reg   <= cmd_wstrb;
                  write_reg   <= cmd_write;
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
                  // Writes return zero read data.
                  rdata_reg   <= '0;
                  resp_reg    <= OKAY;
                  timeout_reg <= 1'b0;
               end
            end
            WR_REQ: begin
               if (aw_fire) begin
                  aw_done_reg <= 1'b1;
               end
               if (w_fire) begin
                  w_done_reg <= 1'b1;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  resp_reg <= bresp;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  rdata_reg <= rdata;
                  resp_reg  <= rresp;
               end
            end
            default: begin
            end
         endcase
         if (abort) begin
            resp_reg    <= DECERR;
            timeout_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench for axi_lite_master (TIMEOUT=8) with a small behavioural
// AXI4-Lite slave: 16-word memory, configurable awready delay, bresp value,
// arready stall and bvalid stall.
// ----------------------------------------------------------------------------
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [31:0] awaddr;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // ------------------------------------------------------------------
   // Behavioural slave
   // ------------------------------------------------------------------
   int          aw_delay  = 0;
   logic [1:0]  bresp_sel = 2'b00;
   logic        ar_stall  = 1'b0;
   logic        b_stall   = 1'b0;

   logic [31:0] mem [0:15];
   int          aw_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_a, w_d;
   logic [3:0]  w_s;

   assign awready = awvalid && (aw_cnt >= aw_delay);
   assign wready  = 1'b1;
   assign arready = !ar_stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_cnt <= 0;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         aw_a   <= '0;
         w_d    <= '0;
         w_s    <= '0;
         bvalid <= 1'b0;
         bresp  <= 2'b00;
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= 2'b00;
      end else begin
         if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
         else if (awvalid && awready) aw_cnt <= 0;
         if (awvalid && awready) begin
            aw_got <= 1'b1;
            aw_a   <= awaddr;
         end
         if (wvalid && wready) begin
            w_got <= 1'b1;
            w_d   <= wdata;
            w_s   <= wstrb;
         end
         if (aw_got && w_got && !bvalid) begin
            for (int b = 0; b < 4; b++) begin
               if (w_s[b]) mem[aw_a[5:2]][8*b +: 8] <= w_d[8*b +: 8];
            end
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= !b_stall;
            bresp  <= bresp_sel;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= mem[araddr[5:2]];
            rresp  <= 2'b00;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Channel monitor (sampled on the falling edge)
   // ------------------------------------------------------------------
   int   cyc = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
   int   aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0;
   logic bready_q = 1'b0;

   always @(negedge clk) begin
      cyc      <= cyc + 1;
      bready_q <= bready;
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (arvalid) ar_hi <= ar_hi + 1;
      if (awvalid && awready) aw_hs_cyc <= cyc;
      if (wvalid && wready)   w_hs_cyc  <= cyc;
      if (bready && !bready_q) b_rise_cyc <= cyc;
   end

   // ------------------------------------------------------------------
   // Checking and transaction tasks
   // ------------------------------------------------------------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Issue one command, wait for its response, keep rsp_ready low for
   // 'hold' cycles while checking the held response, then consume it.
   task automatic do_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int hold,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                         input logic exp_to);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check({tag, "_accept_wait"}, 64'd0, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         check({tag, "_rsp_wait"}, 64'd0, 64'd1);
         return;
      end
      for (int i = 0; i <= hold; i++) begin
         check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
         check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
         check({tag, "_resp"}, 64'(rsp_resp), 64'(exp_resp));
         check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
         check({tag, "_write"}, 64'(rsp_write), 64'(wr));
         check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
         if (i < hold) @(negedge clk);
      end
      $display("txn %s wr=%0d addr=%08h rdata=%08h resp=%0d timeout=%0d",
               tag, wr, addr, rsp_rdata, rsp_resp, rsp_timeout);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
      check({tag, "_cmd_ready_next"}, 64'(cmd_ready), 64'd1);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   logic [127:0] outs;
   assign outs = {cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                  rsp_valid, rsp_write, rsp_timeout, rsp_resp,
                  awaddr, wdata, wstrb, araddr[19:0], rsp_rdata[26:0]};

   initial begin
      int n;
      int aw0, w0, ar0;

      // reset state
      #1;
      check("reset_outputs", outs[63:0], 64'd0);
      check("reset_outputs_hi", outs[127:64], 64'd0);
      repeat (3) @(negedge clk);
      check("reset_cmd_ready_held", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

      // write then read back
      do_cmd("wr_deadbeef", 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 2'b00, 1'b0);
      do_cmd("rd_deadbeef", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);

      // held response
      do_cmd("wr_12345678", 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 32'h0, 2'b00, 1'b0);
      do_cmd("rd_hold5", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 5, 32'h1234_5678, 2'b00, 1'b0);

      // delayed awready, SLVERR response
      aw_delay  = 3;
      bresp_sel = 2'b10;
      #1;
      aw0 = aw_hi;
      w0  = w_hi;
      do_cmd("wr_aw_late", 1'b1, 32'h0000_0010, 32'h5555_AAAA, 4'hF, 0, 32'h0, 2'b10, 1'b0);
      #1;
      check("aw_late_awvalid_cycles", 64'(aw_hi - aw0), 64'd4);
      check("aw_late_wvalid_cycles", 64'(w_hi - w0), 64'd1);
      check("aw_late_bready_rise", 64'(b_rise_cyc), 64'(aw_hs_cyc + 1));
      check("aw_late_w_before_aw", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
      aw_delay  = 0;
      bresp_sel = 2'b00;

      // read timeout
      ar_stall = 1'b1;
      #1;
      ar0 = ar_hi;
      do_cmd("rd_timeout", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h0, 2'b11, 1'b1);
      #1;
      check("timeout_arvalid_cycles", 64'(ar_hi - ar0), 64'd8);
      ar_stall = 1'b0;

      // reset while waiting in WR_RESP
      b_stall = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0008;
      cmd_wdata = 32'hCAFE_F00D;
      cmd_wstrb = 4'hF;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!bready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reached_wr_resp", 64'(bready), 64'd1);
      check("midrst_awaddr_before", 64'(awaddr), 64'h8);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_outputs", outs[63:0], 64'd0);
      check("midrst_outputs_hi", outs[127:64], 64'd0);
      $display("txn midrst wr=1 addr=00000008 aborted by reset");
      @(negedge clk);
      rst     = 1'b0;
      b_stall = 1'b0;
      do_cmd("rd_after_rst", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);

      // byte strobe
      do_cmd("wr_strb1", 1'b1, 32'h0000_0000, 32'h0000_00AA, 4'h1, 0, 32'h0, 2'b00, 1'b0);
      do_cmd("rd_strb1", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'hDEAD_BEAA, 2'b00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
